axis_tlast_framer: RTL and testbench
====================================

AXIS_TLAST_FRAMER -- requirements
Module: axis_tlast_framer

Interface
REQ-001 Parameter DATA_W, default 32: data width in bits of the s_tdata and m_tdata buses.
REQ-002 Parameter LEN_W, default 16: frame length width in bits; this sets the maximum frame length to 2^LEN_W-1 beats.
REQ-003 Parameter DEFAULT_LEN, default 128: frame length used whenever frame_len is sampled as 0.
REQ-004 Parameter CNT_W, default 16: frame counter width in bits.
REQ-005 Port list SHALL be, in order: clk (in, 1, single clock, all logic on rising edge); rst_n (in, 1, asynchronous active-low reset).
REQ-006 en (in, 1): framing enable.
REQ-007 frame_len (in, LEN_W): beats per frame.
REQ-008 s_tdata (in, DATA_W), s_tvalid (in, 1), s_tready (out, 1): upstream AXI-Stream slave, no tlast.
REQ-009 m_tdata (out, DATA_W), m_tvalid (out, 1), m_tready (in, 1), m_tlast (out, 1), m_tuser (out, 1, start of frame): downstream AXI-Stream master.
REQ-010 busy (out, 1): high while a frame is open.
REQ-011 frame_cnt (out, CNT_W): number of completed frames.

Function
REQ-012 Two-state FSM, IDLE and ACTIVE; the state SHALL be IDLE after reset.
REQ-013 IDLE: s_tready=0. If en=1, the FSM SHALL latch len_q = (frame_len==0 ? DEFAULT_LEN : frame_len), clear beat index idx to 0, and enter ACTIVE on the next cycle.
REQ-014 ACTIVE: s_tready = (!m_tvalid || m_tready). A beat is accepted when s_tvalid && s_tready.
REQ-015 Output stage SHALL be one register. An accepted beat appears on m_tdata/m_tvalid on the next cycle, giving 1-cycle latency.
REQ-016 An output beat SHALL hold m_tdata, m_tlast and m_tuser stable until m_tvalid && m_tready.
REQ-017 m_tvalid SHALL clear after a handshake unless a new beat is accepted in the same cycle. Throughput is 1 beat/cycle with m_tready held high.
REQ-018 m_tuser=1 on the beat accepted at idx==0, else 0.
REQ-019 m_tlast=1 on the beat accepted at idx==len_q-1, else 0.
REQ-020 idx SHALL increment per accepted beat and return to 0 after the last beat, never exceeding len_q-1.
REQ-021 len_q=1 SHALL give m_tuser=m_tlast=1 on every beat.
REQ-022 On acceptance of the last beat with en=1, the FSM SHALL relatch len_q from frame_len (0 maps to DEFAULT_LEN) and stay ACTIVE, with no bubble between frames.
REQ-023 On acceptance of the last beat with en=0, the FSM SHALL go to IDLE. s_tready SHALL drop the next cycle, and the last beat still drains from the output register.
REQ-024 en deasserted mid-frame SHALL NOT truncate the frame: the frame completes to len_q beats.
REQ-025 frame_len changes mid-frame SHALL be ignored until the next frame latch.
REQ-026 busy = (state==ACTIVE).
REQ-027 frame_cnt SHALL increment by 1 on each output handshake with m_tlast=1 and wrap modulo 2^CNT_W.
REQ-028 m_tready low SHALL stall acceptance without losing or duplicating beats, and idx SHALL hold.

Reset
REQ-029 rst_n=0 SHALL asynchronously force: state=IDLE, idx=0, len_q=DEFAULT_LEN, m_tvalid=0, m_tdata=0, m_tlast=0, m_tuser=0, s_tready=0, busy=0, frame_cnt=0.
REQ-030 Reset mid-frame SHALL discard the partial frame; the first frame after reset starts with m_tuser=1.
REQ-031 Reset release SHALL be synchronous to clk. No beat is accepted in the first cycle after release.

Configuration
REQ-032 Macro TLAST_FRAME_CNT_EN: when defined, the frame_cnt counter SHALL be implemented per REQ-027.
REQ-033 Without TLAST_FRAME_CNT_EN, frame_cnt SHALL be tied to 0, no counter logic is generated, and all other behaviour is unchanged.

Verification
REQ-034 en=1, frame_len=4, s_tvalid=1 and m_tready=1 continuously, 12 beats -> m_tlast on beats 4/8/12, m_tuser on beats 1/5/9, frame_cnt=3, no bubbles.
REQ-035 frame_len=0 -> frame length 128. frame_len=1 -> every beat has m_tlast=m_tuser=1.
REQ-036 frame_len=8; m_tready toggles randomly 50%; data 0..23 -> output 0..23 in order with none lost or duplicated, m_tlast on values 7/15/23.
REQ-037 en dropped after beat 2 of an 8-beat frame -> remaining 6 beats accepted, m_tlast on beat 8, then busy=0 and s_tready=0.
REQ-038 frame_len changed 4->6 during beat 2 -> current frame ends at beat 4, next frame is 6 beats.
REQ-039 rst_n pulsed low at beat 3 of a 5-beat frame -> outputs reset per REQ-029 immediately; after release the next accepted beat has m_tuser=1. With CNT_W=2 and TLAST_FRAME_CNT_EN defined, frame_cnt wraps 3->0 on the 4th frame.

Source files
------------

// File: rtl/axis_tlast_framer.sv
// axis_tlast_framer: slices a tlast-less AXI-Stream into fixed-length frames.
// It adds m_tlast on the final beat and m_tuser on the first beat of each frame.
// The output stage is a single register, so data leaves one cycle after acceptance.
// Optional macro TLAST_FRAME_CNT_EN builds a wrapping counter of completed frames.
// Without that macro, frame_cnt is tied to zero.
module axis_tlast_framer #(
  parameter int DATA_W      = 32,
  parameter int LEN_W       = 16,
  parameter int DEFAULT_LEN = 128,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              m_tuser,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t            state_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx_q;
  logic [LEN_W-1:0]  len_d;
  logic [DATA_W-1:0] m_tdata_q;
  logic              m_tvalid_q;
  logic              m_tlast_q;
  logic              m_tuser_q;
  logic              accept;
  logic              last_beat;

  // A requested length of zero selects the default frame length.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] l);
    return (l == '0) ? LEN_W'(DEFAULT_LEN) : l;
  endfunction

  // The upstream is accepted only while a frame is open and the output register can take a beat.
  assign s_tready  = (state_q == ACTIVE) && (!m_tvalid_q || m_tready);
  assign accept    = s_tvalid && s_tready;
  assign last_beat = (idx_q == (len_q - LEN_W'(1)));
  assign len_d     = eff_len(frame_len);

  assign m_tdata  = m_tdata_q;
  assign m_tvalid = m_tvalid_q;
  assign m_tlast  = m_tlast_q;
  assign m_tuser  = m_tuser_q;
  assign busy     = (state_q == ACTIVE);

  // Framing FSM plus output register. The length is relatched at every frame start,
  // so mid-frame changes to frame_len or en never truncate the frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= LEN_W'(DEFAULT_LEN);
      idx_q      <= '0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tuser_q  <= 1'b0;
    end else begin
      if (accept) begin
        m_tdata_q  <= s_tdata;
        m_tvalid_q <= 1'b1;
        m_tuser_q  <= (idx_q == '0);
        m_tlast_q  <= last_beat;
      end else if (m_tready) begin
        m_tvalid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (en) begin
            len_q   <= len_d;
            idx_q   <= '0;
            state_q <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (accept) begin
            if (last_beat) begin
              idx_q <= '0;
              if (en) begin
                len_q <= len_d;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              idx_q <= idx_q + LEN_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef TLAST_FRAME_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign cnt_d     = cnt_q + CNT_W'(1);
  assign frame_cnt = cnt_q;

  // Count frames as their last beat leaves the output register; the count wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (m_tvalid_q && m_tready && m_tlast_q) begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_axis_tlast_framer.sv
// Testbench for axis_tlast_framer: random stimulus against a frame-list reference model.
module tb_axis_tlast_framer;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic [LEN_W-1:0]  frame_len = '0;
  logic [DATA_W-1:0] s_tdata = '0;
  logic              s_tvalid = 1'b0;
  logic              s_tready;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready = 1'b0;
  logic              m_tlast;
  logic              m_tuser;
  logic              busy;
  logic [CNT_W-1:0]  frame_cnt;

  axis_tlast_framer #(
    .DATA_W(DATA_W), .LEN_W(LEN_W), .DEFAULT_LEN(128), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .frame_len(frame_len),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .busy(busy), .frame_cnt(frame_cnt)
  );

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              l;
    logic              u;
  } beat_t;

  beat_t out_q[$];
  beat_t exp_q[$];
  int    ts_q[$];
  int    frame_lens[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    data_base = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: handshakes are sampled mid-cycle, ahead of the edge that completes them.
  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) begin
      out_q.push_back({m_tdata, m_tlast, m_tuser});
      ts_q.push_back(cyc);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  // Reference model: frames are laid end to end, with the first and last beat of each tagged.
  task automatic build_exp(input int base, input int n);
    int k = 0;
    exp_q.delete();
    foreach (frame_lens[f]) begin
      for (int b = 0; b < frame_lens[f]; b++) begin
        if (k < n) begin
          exp_q.push_back({DATA_W'(base + k), (b == frame_lens[f] - 1), (b == 0)});
          k++;
        end
      end
    end
  endtask

  function automatic logic [CNT_W-1:0] exp_cnt(input int frames);
`ifdef TLAST_FRAME_CNT_EN
    return CNT_W'(frames % (1 << CNT_W));
`else
    return CNT_W'(frames * 0);
`endif
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0; en = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0; frame_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_q.delete();
    ts_q.delete();
  endtask

  // Source driver: offers n sequential data words, optionally dropping en or changing frame_len.
  task automatic send(input int n, input int pv, input int pr,
                      input int en_off_at, input int fl_at, input int fl_new);
    int   k = 0;
    int   c = 0;
    logic acc;
    while (k < n && c < 3000) begin
      if (k == en_off_at) en = 1'b0;
      if (k == fl_at) frame_len = LEN_W'(fl_new);
      s_tvalid = ($urandom_range(99) < pv);
      s_tdata  = DATA_W'(data_base + k);
      m_tready = ($urandom_range(99) < pr);
      @(negedge clk);
      acc = s_tvalid && s_tready;
      @(posedge clk);
      #1;
      if (acc) k++;
      c++;
    end
    s_tvalid = 1'b0;
    data_base += n;
    checks++;
    if (k < n) begin
      errors++;
      $display("FAIL send_timeout accepted=%0d want=%0d", k, n);
    end
  endtask

  task automatic drain(input int target);
    int c = 0;
    m_tready = 1'b1;
    s_tvalid = 1'b0;
    while (out_q.size() < target && c < 500) begin
      @(posedge clk);
      #1;
      c++;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_q.size() < target) begin
      errors++;
      $display("FAIL drain_timeout got=%0d beats want=%0d", out_q.size(), target);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({m_tvalid, m_tdata, m_tlast, m_tuser} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d=%h l=%b u=%b want all 0", m_tvalid, m_tdata, m_tlast, m_tuser);
    end
    checks++;
    if ({s_tready, busy, frame_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl got rdy=%b busy=%b cnt=%0d want 0 0 0", s_tready, busy, frame_cnt);
    end
    en = 1'b1; frame_len = 16'd4; s_tvalid = 1'b1; s_tdata = 32'hA5A5_0001; m_tready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({m_tvalid, busy, s_tready} !== 3'b011) begin
      errors++;
      $display("FAIL first_cycle got v=%b busy=%b rdy=%b want 0 1 1", m_tvalid, busy, s_tready);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({m_tvalid, m_tuser, m_tdata} !== {1'b1, 1'b1, 32'hA5A5_0001}) begin
      errors++;
      $display("FAIL first_beat got v=%b u=%b d=%h want 1 1 a5a50001", m_tvalid, m_tuser, m_tdata);
    end
  endtask

  task automatic test_basic();
    int base;
    apply_reset();
    en = 1'b1; frame_len = 16'd4; base = data_base;
    send(12, 100, 100, -1, -1, 0);
    drain(12);
    frame_lens = '{4, 4, 4};
    build_exp(base, 12);
    checks++;
    if (out_q.size() != 12) begin
      errors++;
      $display("FAIL basic_count got=%0d want=12", out_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_beat%0d got=%h want=%h", i, out_q[i], exp_q[i]);
      end
    end
    for (int i = 1; i < ts_q.size(); i++) begin
      checks++;
      if (ts_q[i] - ts_q[i-1] != 1) begin
        errors++;
        $display("FAIL basic_bubble beat%0d gap=%0d want=1", i, ts_q[i] - ts_q[i-1]);
      end
    end
    checks++;
    if (frame_cnt !== exp_cnt(3)) begin
      errors++;
      $display("FAIL basic_cnt got=%0d want=%0d", frame_cnt, exp_cnt(3));
    end
  endtask

  task automatic test_len0();
    int base;
    apply_reset();
    en = 1'b1; frame_len = 16'd0; base = data_base;
    send(130, 100, 100, -1, -1, 0);
    drain(130);
    frame_lens = '{128, 128};
    build_exp(base, 130);
    checks++;
    if (out_q.size() != 130) begin
      errors++;
      $display("FAIL len0_count got=%0d want=130", out_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL len0_beat%0d got=%h want=%h", i, out_q[i], exp_q[i]);
      end
    end
    checks++;
    if (frame_cnt !== exp_cnt(1)) begin
      errors++;
      $display("FAIL len0_cnt got=%0d want=%0d", frame_cnt, exp_cnt(1));
    end
  endtask

  task automatic test_len1();
    int base;
    apply_reset();
    en = 1'b1; frame_len = 16'd1; base = data_base;
    send(6, 70, 60, -1, -1, 0);
    drain(6);
    frame_lens = '{1, 1, 1, 1, 1, 1};
    build_exp(base, 6);
    checks++;
    if (out_q.size() != 6) begin
      errors++;
      $display("FAIL len1_count got=%0d want=6", out_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL len1_beat%0d got=%h want=%h", i, out_q[i], exp_q[i]);
      end
    end
    checks++;
    if (frame_cnt !== exp_cnt(6)) begin
      errors++;
      $display("FAIL len1_cnt got=%0d want=%0d", frame_cnt, exp_cnt(6));
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    en = 1'b1; frame_len = 16'd8; data_base = 0;
    send(24, 85, 50, -1, -1, 0);
    drain(24);
    frame_lens = '{8, 8, 8};
    build_exp(0, 24);
    checks++;
    if (out_q.size() != 24) begin
      errors++;
      $display("FAIL bp_count got=%0d want=24", out_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp_beat%0d got=%h want=%h", i, out_q[i], exp_q[i]);
      end
    end
    checks++;
    if (frame_cnt !== exp_cnt(3)) begin
      errors++;
      $display("FAIL bp_cnt got=%0d want=%0d", frame_cnt, exp_cnt(3));
    end
  endtask

  task automatic test_en_drop();
    int base;
    apply_reset();
    en = 1'b1; frame_len = 16'd8; base = data_base;
    send(8, 100, 100, 2, -1, 0);
    drain(8);
    s_tvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    frame_lens = '{8};
    build_exp(base, 8);
    checks++;
    if (out_q.size() != 8) begin
      errors++;
      $display("FAIL endrop_count got=%0d want=8", out_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL endrop_beat%0d got=%h want=%h", i, out_q[i], exp_q[i]);
      end
    end
    checks++;
    if ({busy, s_tready} !== 2'b00) begin
      errors++;
      $display("FAIL endrop_idle got busy=%b rdy=%b want 0 0", busy, s_tready);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic test_len_change();
    int base;
    apply_reset();
    en = 1'b1; frame_len = 16'd4; base = data_base;
    send(10, 100, 100, -1, 2, 6);
    drain(10);
    frame_lens = '{4, 6};
    build_exp(base, 10);
    checks++;
    if (out_q.size() != 10) begin
      errors++;
      $display("FAIL lenchg_count got=%0d want=10", out_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL lenchg_beat%0d got=%h want=%h", i, out_q[i], exp_q[i]);
      end
    end
    checks++;
    if (frame_cnt !== exp_cnt(2)) begin
      errors++;
      $display("FAIL lenchg_cnt got=%0d want=%0d", frame_cnt, exp_cnt(2));
    end
  endtask

  task automatic test_reset_mid();
    int base;
    apply_reset();
    en = 1'b1; frame_len = 16'd5;
    send(3, 100, 100, -1, -1, 0);
    s_tvalid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_tvalid, m_tdata, m_tlast, m_tuser, s_tready, busy, frame_cnt} !== '0) begin
      errors++;
      $display("FAIL midrst_async got v=%b d=%h l=%b u=%b rdy=%b busy=%b cnt=%0d want all 0",
               m_tvalid, m_tdata, m_tlast, m_tuser, s_tready, busy, frame_cnt);
    end
    s_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_q.delete();
    ts_q.delete();
    data_base = 200;
    base = data_base;
    send(5, 100, 100, -1, -1, 0);
    drain(5);
    frame_lens = '{5};
    build_exp(base, 5);
    checks++;
    if (out_q.size() != 5) begin
      errors++;
      $display("FAIL midrst_count got=%0d want=5", out_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL midrst_beat%0d got=%h want=%h", i, out_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_cnt_wrap();
    apply_reset();
    en = 1'b1; frame_len = 16'd2;
    for (int i = 1; i <= 5; i++) begin
      send(2, 100, 100, -1, -1, 0);
      drain(2 * i);
      checks++;
      if (frame_cnt !== exp_cnt(i)) begin
        errors++;
        $display("FAIL cntwrap_frame%0d got=%0d want=%0d", i, frame_cnt, exp_cnt(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len0();
    test_len1();
    test_backpressure();
    test_en_drop();
    test_len_change();
    test_reset_mid();
    test_cnt_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
